// File: rtl/mmc1_pkg.sv
// Shared constants and FSM encoding for the MMC1 serial-load bus master.
package mmc1_pkg;

    localparam logic [1:0] REG_CONTROL = 2'b00;
    localparam logic [1:0] REG_CHR0    = 2'b01;
    localparam logic [1:0] REG_CHR1    = 2'b10;
    localparam logic [1:0] REG_PRG     = 2'b11;

    localparam int         SHIFT_LEN = 5;
    localparam logic [2:0] LAST_BIT  = 3'(SHIFT_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RST_WR = 3'd1,
        ST_BIT_WR = 3'd2,
        ST_GAP    = 3'd3,
        ST_FIN    = 3'd4
    } state_e;

    function automatic logic is_write(input state_e s);
        return (s == ST_RST_WR) || (s == ST_BIT_WR);
    endfunction

endpackage

// File: rtl/mmc1_m2_phase_gen.sv
// Free-running bus-cycle phase counter: produces M2, the cycle boundary strobe
// and the nROMSEL window, all aligned so the consumer can register bus outputs.
module mmc1_m2_phase_gen #(
    parameter int M2_DIV     = 6,
    parameter int ROMSEL_DLY = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic m2_o,
    output logic cycle_start_o,
    output logic romsel_window_o
);

    localparam int             PERIOD    = 2 * M2_DIV;
    localparam int             PW        = $clog2(PERIOD);
    localparam logic [PW-1:0]  LAST      = PW'(PERIOD - 1);
    localparam logic [PW-1:0]  HI_START  = PW'(M2_DIV);
    localparam logic [PW-1:0]  WIN_START = PW'(M2_DIV + ROMSEL_DLY);

    logic [PW-1:0] phase_q, phase_d;
    logic          m2_q;

    always_comb begin
        phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q <= '0;
            m2_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            m2_q    <= (phase_d >= HI_START);
        end
    end

    // Both strobes look one phase ahead: they qualify the edge that enters
    // phase 0 / the window, so registered outputs line up with the phase.
    assign cycle_start_o   = (phase_q == LAST);
    assign romsel_window_o = (phase_d >= WIN_START);
    assign m2_o            = m2_q;

endmodule

// File: rtl/mmc1_serial_writer.sv
// Emulates 6502 write cycles to load one MMC1 register through its 5-bit
// serial port, optionally preceded by a shift-register reset write.
module mmc1_serial_writer
    import mmc1_pkg::*;
#(
    parameter int M2_DIV     = 6,
    parameter int ROMSEL_DLY = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [1:0] REQ_REG,
    input  logic [4:0] REQ_DATA,
    input  logic       REQ_RESET,
    output logic       BUSY,
    output logic       DONE,
    output logic       CPU_M2,
    output logic       CPU_A13,
    output logic       CPU_A14,
    output logic       nCPU_ROMSEL,
    output logic       nCPU_RW,
    output logic       CPU_D0,
    output logic       CPU_D7
);

    localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    logic cycle_start, romsel_window, m2;

    mmc1_m2_phase_gen #(
        .M2_DIV     (M2_DIV),
        .ROMSEL_DLY (ROMSEL_DLY)
    ) u_phase (
        .clk_i           (CLK),
        .rst_i           (RST),
        .m2_o            (m2),
        .cycle_start_o   (cycle_start),
        .romsel_window_o (romsel_window)
    );

    state_e        state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          post_rst_q, post_rst_d;
    logic [4:0]    data_q, data_d;
    logic [1:0]    addr_q, addr_d;
    logic          wr_q, wr_d;
    logic          d0_q, d0_d;
    logic          d7_q, d7_d;
    logic          nrom_q, nrom_d;
    logic          rdy_q, busy_q, done_q;
    logic          accept;
    logic [4:0]    data_src;

    assign accept   = (state_q == ST_IDLE) && rdy_q && REQ_VALID;
    assign data_src = accept ? REQ_DATA : data_q;

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        gap_d      = gap_q;
        post_rst_d = post_rst_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = REQ_RESET ? ST_RST_WR : ST_BIT_WR;
                    bit_d      = '0;
                    gap_d      = '0;
                    post_rst_d = 1'b0;
                end
            end
            // wr_q marks that this state's bus cycle has actually run; a
            // mid-cycle acceptance waits here until the next phase 0.
            ST_RST_WR, ST_BIT_WR: begin
                if (cycle_start && wr_q) begin
                    state_d    = ST_GAP;
                    post_rst_d = (state_q == ST_RST_WR);
                end
            end
            ST_GAP: begin
                if (cycle_start) begin
                    if (gap_q == GAP_LAST) begin
                        gap_d = '0;
                        if (post_rst_q) begin
                            state_d    = ST_BIT_WR;
                            post_rst_d = 1'b0;
                        end else if (bit_q == LAST_BIT) begin
                            state_d = ST_FIN;
                        end else begin
                            state_d = ST_BIT_WR;
                            bit_d   = bit_q + 3'd1;
                        end
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_d   = wr_q;
        d0_d   = d0_q;
        d7_d   = d7_q;
        data_d = data_src;
        addr_d = accept ? REQ_REG : ((state_d == ST_IDLE) ? REG_CONTROL : addr_q);
        // Data and write strobe change only at bus cycle boundaries.
        if (cycle_start) begin
            wr_d = is_write(state_d);
            d7_d = (state_d == ST_RST_WR);
            d0_d = (state_d == ST_BIT_WR) && data_src[bit_d];
        end
        nrom_d = ~(wr_d & romsel_window);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            bit_q      <= '0;
            gap_q      <= '0;
            post_rst_q <= 1'b0;
            data_q     <= '0;
            addr_q     <= REG_CONTROL;
            wr_q       <= 1'b0;
            d0_q       <= 1'b0;
            d7_q       <= 1'b0;
            nrom_q     <= 1'b1;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            post_rst_q <= post_rst_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            d0_q       <= d0_d;
            d7_q       <= d7_d;
            nrom_q     <= nrom_d;
            rdy_q      <= (state_d == ST_IDLE);
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_FIN);
        end
    end

    assign REQ_READY   = rdy_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign CPU_M2      = m2;
    assign CPU_A13     = addr_q[0];
    assign CPU_A14     = addr_q[1];
    assign nCPU_RW     = ~wr_q;
    assign nCPU_ROMSEL = nrom_q;
    assign CPU_D0      = d0_q;
    assign CPU_D7      = d7_q;

endmodule

// File: tb/tb_mmc1_serial_writer.sv
// Directed bench: bus monitor with a behavioural MMC1 receiver, plus timing checks.
module tb_mmc1_serial_writer;

    localparam int M2_DIV     = 6;
    localparam int ROMSEL_DLY = 1;
    localparam int GAP_CYCLES = 1;
    localparam int PERIOD     = 2 * M2_DIV;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       REQ_VALID = 1'b0;
    logic [1:0] REQ_REG = 2'b00;
    logic [4:0] REQ_DATA = 5'b0;
    logic       REQ_RESET = 1'b0;
    logic       REQ_READY, BUSY, DONE, CPU_M2, CPU_A13, CPU_A14;
    logic       nCPU_ROMSEL, nCPU_RW, CPU_D0, CPU_D7;

    mmc1_serial_writer #(
        .M2_DIV(M2_DIV), .ROMSEL_DLY(ROMSEL_DLY), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_REG(REQ_REG), .REQ_DATA(REQ_DATA), .REQ_RESET(REQ_RESET),
        .BUSY(BUSY), .DONE(DONE), .CPU_M2(CPU_M2), .CPU_A13(CPU_A13),
        .CPU_A14(CPU_A14), .nCPU_ROMSEL(nCPU_ROMSEL), .nCPU_RW(nCPU_RW),
        .CPU_D0(CPU_D0), .CPU_D7(CPU_D7)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int rel   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic       d0;
        logic       d7;
        logic [1:0] a;
        int         c;
    } wr_t;

    wr_t        wq[$];
    logic [4:0] mreg [4];
    logic [4:0] msh = 5'b0;
    int         mcnt = 0;
    logic       prev_rw = 1'b1, prev_rom = 1'b1, prev_m2 = 1'b0;
    int         m2_rises = 0, m2_rise_cyc = 0, rom_dly = -1;
    int         last_bus = -100, min_sep = 100, done_cnt = 0, rom_bad = 0;

    // Bus monitor and behavioural MMC1 serial receiver.
    always @(negedge CLK) begin
        prev_m2  <= CPU_M2;
        prev_rw  <= nCPU_RW;
        prev_rom <= nCPU_ROMSEL;
        if (CPU_M2 && !prev_m2) begin
            m2_rises    <= m2_rises + 1;
            m2_rise_cyc <= cyc;
        end
        if (!nCPU_ROMSEL && prev_rom) rom_dly <= cyc - m2_rise_cyc;
        if (!nCPU_ROMSEL && (nCPU_RW || !CPU_M2)) rom_bad <= rom_bad + 1;
        if (DONE) done_cnt <= done_cnt + 1;
        if (RST) begin
            last_bus <= -100;
        end else if (!nCPU_RW && prev_rw) begin
            wq.push_back('{CPU_D0, CPU_D7, {CPU_A14, CPU_A13}, cyc});
            if (m2_rises - last_bus < min_sep) min_sep <= m2_rises - last_bus;
            last_bus <= m2_rises;
            if (CPU_D7) begin
                msh  <= 5'b0;
                mcnt <= 0;
            end else if (mcnt == 4) begin
                mreg[{CPU_A14, CPU_A13}] <= {CPU_D0, msh[4:1]};
                msh  <= 5'b0;
                mcnt <= 0;
            end else begin
                msh  <= {CPU_D0, msh[4:1]};
                mcnt <= mcnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    function automatic int ph();
        return (cyc - rel) % PERIOD;
    endfunction

    function automatic logic [31:0] d0seq(input int from, input int n);
        logic [31:0] s = '0;
        for (int i = 0; i < n; i++) s[i] = wq[from + i].d0;
        return s;
    endfunction

    function automatic int count_d7(input int from);
        int n = 0;
        for (int i = from; i < wq.size(); i++) if (wq[i].d7) n++;
        return n;
    endfunction

    function automatic int count_bad_addr(input int from, input int to, input logic [1:0] a);
        int n = 0;
        for (int i = from; i < to; i++) if (wq[i].a !== a) n++;
        return n;
    endfunction

    function automatic logic [9:0] out_vec();
        return {CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D0, CPU_D7, BUSY, DONE, REQ_READY};
    endfunction

    task automatic wait_phase(input int p);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!(ph() == p && REQ_READY === 1'b1) && k < 100);
        chk("wait_phase_timeout", 32'(k < 100), 32'd1);
    endtask

    task automatic send(input logic [1:0] r, input logic [4:0] d, input logic rs,
                        input int p, output int c);
        wait_phase(p);
        REQ_REG   = r;
        REQ_DATA  = d;
        REQ_RESET = rs;
        REQ_VALID = 1'b1;
        c         = cyc;
        tick();
        REQ_VALID = 1'b0;
    endtask

    task automatic wait_done(output int dcyc);
        int k = 0;
        dcyc = -1;
        while (k < 400 && dcyc < 0) begin
            tick();
            k++;
            if (DONE === 1'b1) dcyc = cyc;
        end
        chk("done_timeout", 32'(dcyc >= 0), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, d, d2, dc0, k;

        // Reset state and READY release
        repeat (3) tick();
        chk("reset_outputs", 32'(out_vec()), 32'b0110000000);
        RST = 1'b0;
        rel = cyc;
        chk("ready_before_first_clk", 32'(REQ_READY), 32'd0);
        tick();
        chk("ready_after_release", 32'(REQ_READY), 32'd1);

        // Idle bus and M2 phase
        wait_phase(M2_DIV - 1);
        chk("m2_low_phase5", 32'(CPU_M2), 32'd0);
        chk("idle_bus", 32'({nCPU_RW, nCPU_ROMSEL, CPU_A14, CPU_A13, CPU_D0, CPU_D7, BUSY}), 32'b1100000);
        tick();
        chk("m2_high_phase6", 32'(CPU_M2), 32'd1);

        // Control = 01100, no reset write
        wq.delete();
        dc0 = done_cnt;
        send(2'b00, 5'b01100, 1'b0, 0, c);
        wait_done(d);
        chk("t1_nwrites", 32'(wq.size()), 32'd5);
        chk("t1_latency", 32'(wq[0].c - c), 32'd12);
        chk("t1_d0_seq", d0seq(0, 5), 32'b01100);
        chk("t1_d7", 32'(count_d7(0)), 32'd0);
        chk("t1_addr", 32'(count_bad_addr(0, 5, 2'b00)), 32'd0);
        chk("t1_control", 32'(mreg[0]), 32'b01100);
        chk("t1_done_time", 32'(d - wq[0].c), 32'd120);
        chk("t1_ready_in_done", 32'(REQ_READY), 32'd0);
        tick();
        chk("t1_done_count", 32'(done_cnt - dc0), 32'd1);
        chk("t1_ready_after", 32'(REQ_READY), 32'd1);

        // PRG = 10101 with reset write
        wq.delete();
        send(2'b11, 5'b10101, 1'b1, 0, c);
        wait_done(d);
        chk("t2_nwrites", 32'(wq.size()), 32'd6);
        chk("t2_first_d7d0", 32'({wq[0].d7, wq[0].d0}), 32'b10);
        chk("t2_d0_seq", d0seq(1, 5), 32'b10101);
        chk("t2_d7_rest", 32'(count_d7(1)), 32'd0);
        chk("t2_addr", 32'(count_bad_addr(0, 6, 2'b11)), 32'd0);
        chk("t2_prg", 32'(mreg[3]), 32'b10101);
        chk("t2_done_time", 32'(d - wq[0].c), 32'd144);

        // Acceptance at phase 3
        wq.delete();
        send(2'b01, 5'b00011, 1'b0, 3, c);
        wait_done(d);
        chk("t3_latency", 32'(wq[0].c - c), 32'd9);
        chk("t3_romsel_dly", 32'(rom_dly), 32'(ROMSEL_DLY));
        chk("t3_chr0", 32'(mreg[1]), 32'b00011);

        // Back-to-back with VALID held high; request lines change while busy
        wq.delete();
        wait_phase(4);
        REQ_REG   = 2'b10;
        REQ_DATA  = 5'b11001;
        REQ_RESET = 1'b0;
        REQ_VALID = 1'b1;
        tick();
        chk("b2b_busy", 32'({BUSY, REQ_READY}), 32'b10);
        REQ_REG  = 2'b11;
        REQ_DATA = 5'b00110;
        wait_done(d);
        chk("b2b_ready_in_done", 32'(REQ_READY), 32'd0);
        tick();
        chk("b2b_ready_after_done", 32'({BUSY, REQ_READY}), 32'b01);
        tick();
        chk("b2b_second_accept", 32'({BUSY, REQ_READY}), 32'b10);
        REQ_VALID = 1'b0;
        wait_done(d2);
        chk("b2b_nwrites", 32'(wq.size()), 32'd10);
        chk("b2b_addr_a", 32'(count_bad_addr(0, 5, 2'b10)), 32'd0);
        chk("b2b_addr_b", 32'(count_bad_addr(5, 10, 2'b11)), 32'd0);
        chk("b2b_chr1", 32'(mreg[2]), 32'b11001);
        chk("b2b_prg", 32'(mreg[3]), 32'b00110);
        chk("min_write_sep", 32'(min_sep >= 2), 32'd1);

        // Reset during the third bit write
        wq.delete();
        send(2'b00, 5'b11111, 1'b0, 0, c);
        k = 0;
        while (wq.size() < 3 && k < 200) begin tick(); k++; end
        k = 0;
        while (nCPU_ROMSEL !== 1'b0 && k < 20) begin tick(); k++; end
        chk("mid_write_rom_low", 32'({nCPU_ROMSEL, nCPU_RW}), 32'b00);
        dc0 = done_cnt;
        RST = 1'b1;
        #1;
        chk("rst_immediate", 32'(out_vec()), 32'b0110000000);
        repeat (3) tick();
        chk("rst_no_done", 32'(done_cnt - dc0), 32'd0);
        chk("rst_held", 32'(out_vec()), 32'b0110000000);
        RST = 1'b0;
        rel = cyc;

        wq.delete();
        send(2'b01, 5'b10010, 1'b1, 5, c);
        wait_done(d);
        chk("rec_latency", 32'(wq[0].c - c), 32'd7);
        chk("rec_nwrites", 32'(wq.size()), 32'd6);
        chk("rec_done_time", 32'(d - wq[0].c), 32'd144);
        chk("rec_chr0", 32'(mreg[1]), 32'b10010);
        chk("romsel_outside_write", 32'(rom_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
